// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit CPU: subcycle names, instruction fields and
// the data-bus driver select.
package cpu_pkg;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } subcycle_t;

    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;
    localparam logic [3:0] OPR_IO      = 4'hE;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_PC   = 2'd1,
        BUS_REG  = 2'd2,
        BUS_ACC  = 2'd3
    } bus_sel_t;

endpackage

// File: rtl/inst_predecode.sv
// Combinational classification of a fetched {OPR,OPA} word into the classes
// that affect bus timing: two-word, SRC, I/O group and I/O write.
module inst_predecode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opr,
    input  logic [3:0] i_opa,
    output logic       o_is_two_word,
    output logic       o_is_src,
    output logic       o_is_io,
    output logic       o_is_io_write
);

    always_comb begin
        o_is_two_word = 1'b0;
        o_is_src      = (i_opr == OPR_FIM_SRC) && i_opa[0];
        o_is_io       = (i_opr == OPR_IO);
        // WRM..WR3 occupy OPA 0-7 of the I/O group
        o_is_io_write = (i_opr == OPR_IO) && !i_opa[3];
        case (i_opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: o_is_two_word = 1'b1;
            OPR_FIM_SRC:                         o_is_two_word = !i_opa[0];
            default:                             o_is_two_word = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_sequencer.sv
// Instruction-cycle sequencer: owns the A1..X3 subcycle timing, latches the
// fetched OPR/OPA nibbles, tracks two-word instructions and decodes bus drive.
module bus_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_RAM_BANKS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               data_in,
    input  logic [NUM_RAM_BANKS-1:0] ram_bank_sel,
    output logic [2:0]               cycle,
    output logic                     sync,
    output logic [3:0]               inst_opr,
    output logic [3:0]               inst_opa,
    output logic                     second_word,
    output logic                     pc_advance,
    output logic                     bus_oe,
    output logic [1:0]               bus_sel,
    output logic                     rom_cmd,
    output logic [NUM_RAM_BANKS-1:0] ram_cmd
);

    subcycle_t r_cycle;
    subcycle_t w_cycle_next;
    logic [3:0] r_opr;
    logic [3:0] r_opa;
    logic       r_second;

    logic     w_two_word;
    logic     w_is_src;
    logic     w_is_io;
    logic     w_is_io_write;
    logic     w_src_act;
    logic     w_io_act;
    logic     w_io_wr_act;
    logic     w_drive;
    bus_sel_t w_sel;
    logic     w_cmd_win;

    inst_predecode u_predecode (
        .i_opr         (r_opr),
        .i_opa         (r_opa),
        .o_is_two_word (w_two_word),
        .o_is_src      (w_is_src),
        .o_is_io       (w_is_io),
        .o_is_io_write (w_is_io_write)
    );

    // Word 2 carries address/data bits only, so its decode is masked.
    assign w_src_act   = w_is_src && !r_second;
    assign w_io_act    = w_is_io && !r_second;
    assign w_io_wr_act = w_is_io_write && !r_second;

    always_comb begin
        w_cycle_next = subcycle_t'(r_cycle + 3'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle  <= A1;
            r_opr    <= '0;
            r_opa    <= '0;
            r_second <= 1'b0;
        end else begin
            r_cycle <= w_cycle_next;
            if (r_cycle == M1) r_opr <= data_in;
            if (r_cycle == M2) r_opa <= data_in;
            if (r_cycle == X3) r_second <= r_second ? 1'b0 : w_two_word;
        end
    end

    always_comb begin
        w_drive   = 1'b0;
        w_sel     = BUS_NONE;
        w_cmd_win = 1'b0;
        case (r_cycle)
            A1, A2: begin
                w_drive = 1'b1;
                w_sel   = BUS_PC;
            end
            A3: begin
                w_drive   = 1'b1;
                w_sel     = BUS_PC;
                w_cmd_win = 1'b1;
            end
            M2: w_cmd_win = w_io_act;
            X2: begin
                if (w_src_act) begin
                    w_drive   = 1'b1;
                    w_sel     = BUS_REG;
                    w_cmd_win = 1'b1;
                end else if (w_io_wr_act) begin
                    w_drive = 1'b1;
                    w_sel   = BUS_ACC;
                end
            end
            X3: begin
                if (w_src_act) begin
                    w_drive = 1'b1;
                    w_sel   = BUS_REG;
                end
            end
            default: ;
        endcase
        // Keep the pins quiet while reset is held, whatever the counter says.
        if (reset) begin
            w_drive   = 1'b0;
            w_sel     = BUS_NONE;
            w_cmd_win = 1'b0;
        end
    end

    assign cycle       = r_cycle;
    assign sync        = (r_cycle == X3);
    assign pc_advance  = (r_cycle == X3);
    assign inst_opr    = r_opr;
    assign inst_opa    = r_opa;
    assign second_word = r_second;
    assign bus_oe      = w_drive;
    assign bus_sel     = w_sel;
    assign rom_cmd     = !w_cmd_win;
    assign ram_cmd     = w_cmd_win ? ~ram_bank_sel : {NUM_RAM_BANKS{1'b1}};

endmodule
